// File: rtl/gpr_read_arbiter.sv
// gpr_read_arbiter: arbitrates the shared rs3 GPR read port between the
// scoreboard issue path and NUM_REQS auxiliary readers.
//   - issue has default priority; aux wins once its starvation counter
//     reaches STARVE_LIMIT; issue is forced back after two aux wins in a row
//   - round-robin among aux requesters
//   - 1-stage tagged response pipeline matching the registered RAM read
// Optional feature: define GPR_ARB_PERF_EN to add three 32-bit saturating
// performance counters as extra output ports.
module gpr_read_arbiter #(
  parameter  int NUM_REQS     = 2,
  parameter  int ADDRW        = 6,
  parameter  int DATAW        = 128,
  parameter  int STARVE_LIMIT = 4,
  localparam int IDXW         = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic [ADDRW-1:0]          issue_addr,
  output logic                      issue_ready,
  output logic                      issue_rsp_valid,
  output logic [DATAW-1:0]          issue_rsp_data,
  input  logic [NUM_REQS-1:0]       aux_valid,
  input  logic [NUM_REQS*ADDRW-1:0] aux_addr,
  output logic [NUM_REQS-1:0]       aux_ready,
  output logic                      aux_rsp_valid,
  output logic [IDXW-1:0]           aux_rsp_idx,
  output logic [DATAW-1:0]          aux_rsp_data,
  output logic                      ram_read,
  output logic [ADDRW-1:0]          ram_raddr,
  input  logic [DATAW-1:0]          ram_rdata
`ifdef GPR_ARB_PERF_EN
  ,
  output logic [31:0]               perf_issue_stalls,
  output logic [31:0]               perf_aux_grants,
  output logic [31:0]               perf_forced_grants
`endif
);

  localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [1:0]    ISSUE_MAX  = 2'd2;
  localparam logic [IDXW:0] NUM_REQS_W = (IDXW+1)'(NUM_REQS);

  // Registered arbitration state
  logic [IDXW-1:0]  rr_ptr;
  logic [3:0]       aux_cnt;
  logic [1:0]       iss_cnt;

  // Response tag captured on the grant
  logic             rsp_valid;
  logic             rsp_is_aux;
  logic [IDXW-1:0]  rsp_idx;
  logic             rsp_zero;

  // Combinational grant decision
  logic             any_aux;
  logic             force_issue;
  logic             force_aux;
  logic             grant_aux;
  logic             grant_issue;
  logic [IDXW-1:0]  rr_idx;
  logic [IDXW-1:0]  rr_next;
  logic [ADDRW-1:0] aux_sel_addr;

  // Round-robin search: first valid aux requester at or after rr_ptr.
  always_comb begin
    logic [IDXW:0] cand;
    logic          found;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    rr_idx = '0;
    found  = 1'b0;
    cand   = '0;
    for (int off = 0; off < NUM_REQS; off++) begin
      cand = {1'b0, rr_ptr} + (IDXW+1)'(off);
      if (cand >= NUM_REQS_W) cand = cand - NUM_REQS_W;
      if (!found && aux_valid[cand[IDXW-1:0]]) begin
        rr_idx = cand[IDXW-1:0];
        found  = 1'b1;
      end
    end
  end

  // Source selection: issue by default, starvation overrides either way.
  always_comb begin
    logic [IDXW:0] nxt;
    any_aux     = |aux_valid;
    force_issue = issue_valid && (iss_cnt == ISSUE_MAX);
    force_aux   = any_aux && (aux_cnt == STARVE_MAX) && !force_issue;
    grant_aux   = !reset && any_aux && (force_aux || !issue_valid);
    grant_issue = !reset && issue_valid && !grant_aux;
    nxt = {1'b0, rr_idx} + (IDXW+1)'(1);
    if (nxt >= NUM_REQS_W) nxt = '0;
    rr_next = nxt[IDXW-1:0];
  end

  // One-hot aux grant and the granted requester's address.
  always_comb begin
    aux_ready    = '0;
    aux_sel_addr = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (rr_idx == IDXW'(k)) aux_sel_addr = aux_addr[k*ADDRW +: ADDRW];
    end
    if (grant_aux) aux_ready[rr_idx] = 1'b1;
  end

  assign issue_ready = grant_issue;
  assign ram_read    = grant_issue | grant_aux;
  assign ram_raddr   = grant_aux ? aux_sel_addr : issue_addr;

  // Round-robin pointer and both starvation counters.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every update in this
    // block sees the pre-edge values of the others.
    if (reset) begin
      rr_ptr  <= '0;
      aux_cnt <= '0;
      iss_cnt <= '0;
    end else begin
      if (grant_aux) rr_ptr <= rr_next;

      if (grant_aux || !any_aux)     aux_cnt <= '0;
      else if (aux_cnt != STARVE_MAX) aux_cnt <= aux_cnt + 4'd1;

      if (grant_issue || !issue_valid)           iss_cnt <= '0;
      else if (grant_aux && iss_cnt != ISSUE_MAX) iss_cnt <= iss_cnt + 2'd1;
    end
  end

  // Response tag follows the grant by one cycle, like the RAM data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_is_aux <= 1'b0;
      rsp_idx    <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      rsp_valid  <= grant_issue | grant_aux;
      rsp_is_aux <= grant_aux;
      rsp_zero   <= grant_issue && (issue_addr == '0);
      if (grant_aux) rsp_idx <= rr_idx;
    end
  end

  // A response in flight when reset arrives is dropped, not delivered.
  assign issue_rsp_valid = rsp_valid && !rsp_is_aux && !reset;
  assign aux_rsp_valid   = rsp_valid &&  rsp_is_aux && !reset;
  assign aux_rsp_idx     = reset ? '0 : rsp_idx;
  assign issue_rsp_data  = rsp_zero ? '0 : ram_rdata;
  assign aux_rsp_data    = ram_rdata;

`ifdef GPR_ARB_PERF_EN
  logic stall_evt;
  logic forced_evt;

  assign stall_evt  = issue_valid && !grant_issue;
  assign forced_evt = (grant_aux && force_aux && issue_valid) ||
                      (grant_issue && force_issue && any_aux);

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issue_stalls  <= '0;
      perf_aux_grants    <= '0;
      perf_forced_grants <= '0;
    end else begin
      if (stall_evt && perf_issue_stalls != '1)
        perf_issue_stalls <= perf_issue_stalls + 32'd1;
      if (grant_aux && perf_aux_grants != '1)
        perf_aux_grants <= perf_aux_grants + 32'd1;
      if (forced_evt && perf_forced_grants != '1)
        perf_forced_grants <= perf_forced_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpr_read_arbiter.sv
// Bench for gpr_read_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
// Define GPR_ARB_PERF_EN to also check the performance counters.
module tb_gpr_read_arbiter;

  localparam int N      = 2;
  localparam int ADDRW  = 6;
  localparam int DATAW  = 128;
  localparam int LIMIT  = 4;
  localparam int IDXW   = 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   issue_valid;
  logic [ADDRW-1:0]       issue_addr;
  logic                   issue_ready;
  logic                   issue_rsp_valid;
  logic [DATAW-1:0]       issue_rsp_data;
  logic [N-1:0]           aux_valid;
  logic [N*ADDRW-1:0]     aux_addr;
  logic [N-1:0]           aux_ready;
  logic                   aux_rsp_valid;
  logic [IDXW-1:0]        aux_rsp_idx;
  logic [DATAW-1:0]       aux_rsp_data;
  logic                   ram_read;
  logic [ADDRW-1:0]       ram_raddr;
  logic [DATAW-1:0]       ram_rdata;
`ifdef GPR_ARB_PERF_EN
  logic [31:0]            perf_issue_stalls;
  logic [31:0]            perf_aux_grants;
  logic [31:0]            perf_forced_grants;
`endif

  gpr_read_arbiter #(
    .NUM_REQS(N), .ADDRW(ADDRW), .DATAW(DATAW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .issue_rsp_valid(issue_rsp_valid), .issue_rsp_data(issue_rsp_data),
    .aux_valid(aux_valid), .aux_addr(aux_addr), .aux_ready(aux_ready),
    .aux_rsp_valid(aux_rsp_valid), .aux_rsp_idx(aux_rsp_idx), .aux_rsp_data(aux_rsp_data),
    .ram_read(ram_read), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
`ifdef GPR_ARB_PERF_EN
    ,
    .perf_issue_stalls(perf_issue_stalls),
    .perf_aux_grants(perf_aux_grants),
    .perf_forced_grants(perf_forced_grants)
`endif
  );

  always #5 clk = ~clk;

  // GPR RAM stand-in with the 1-cycle registered read.
  logic [DATAW-1:0] mem [1<<ADDRW];
  always @(posedge clk) if (ram_read) ram_rdata <= mem[ram_raddr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_aux_wait;   // consecutive cycles aux waited without a grant
  int               m_aux_run;    // consecutive aux grants while issue waited
  int               m_rr;         // next requester to favour
  int               m_stalls, m_aux_grants, m_forced;
  bit               exp_iss_v, exp_aux_v;
  int               exp_idx;
  logic [DATAW-1:0] exp_data;

  task automatic check(input string tag, input logic [DATAW-1:0] obs, input logic [DATAW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_aux_wait = 0; m_aux_run = 0; m_rr = 0;
    m_stalls = 0; m_aux_grants = 0; m_forced = 0;
    exp_iss_v = 0; exp_aux_v = 0; exp_idx = 0; exp_data = '0;
  endtask

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_issue_ready", issue_ready, 0);
      check("rst_aux_ready", aux_ready, 0);
      check("rst_issue_rsp_valid", issue_rsp_valid, 0);
      check("rst_aux_rsp_valid", aux_rsp_valid, 0);
      check("rst_aux_rsp_idx", aux_rsp_idx, 0);
      check("rst_ram_read", ram_read, 0);
    end
    model_reset();
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic step(input logic iv, input logic [ADDRW-1:0] ia,
                      input logic [N-1:0] av, input logic [N*ADDRW-1:0] aa);
    bit any, issue_must, aux_must, win_aux, win_iss;
    int k;
    logic [ADDRW-1:0] ka;
    @(negedge clk);
    reset = 1'b0; issue_valid = iv; issue_addr = ia; aux_valid = av; aux_addr = aa;
    #1;
    // responses owed from the previous cycle's grant
    check("issue_rsp_valid", issue_rsp_valid, exp_iss_v);
    check("aux_rsp_valid", aux_rsp_valid, exp_aux_v);
    if (exp_iss_v) check("issue_rsp_data", issue_rsp_data, exp_data);
    if (exp_aux_v) begin
      check("aux_rsp_idx", aux_rsp_idx, exp_idx);
      check("aux_rsp_data", aux_rsp_data, exp_data);
    end
    // this cycle's winner
    any        = (av != 0);
    issue_must = iv && (m_aux_run >= 2);
    aux_must   = any && (m_aux_wait >= LIMIT) && !issue_must;
    win_aux    = any && (aux_must || !iv);
    win_iss    = iv && !win_aux;
    k = 0;
    if (win_aux)
      for (int i = N - 1; i >= 0; i--)
        if (av[(m_rr + i) % N]) k = (m_rr + i) % N;
    ka = aa[k*ADDRW +: ADDRW];
    check("issue_ready", issue_ready, win_iss);
    check("aux_ready", aux_ready, win_aux ? (N'(1) << k) : N'(0));
    check("ram_read", ram_read, win_aux || win_iss);
    check("ram_raddr", ram_raddr, win_aux ? ka : ia);
    // advance model
    if (iv && !win_iss) m_stalls++;
    if (win_aux) m_aux_grants++;
    if ((win_aux && aux_must && iv) || (win_iss && issue_must && any)) m_forced++;
    if (win_aux) begin
      m_aux_wait = 0;
      m_rr       = (k + 1) % N;
      m_aux_run  = iv ? m_aux_run + 1 : 0;
    end else begin
      m_aux_wait = any ? ((m_aux_wait + 1 > LIMIT) ? LIMIT : m_aux_wait + 1) : 0;
      m_aux_run  = 0;
    end
    exp_iss_v = win_iss;
    exp_aux_v = win_aux;
    exp_idx   = k;
    exp_data  = win_aux ? mem[ka] : ((ia == 0) ? '0 : mem[ia]);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 0; issue_addr = '0; aux_valid = '0; aux_addr = '0;
    for (int a = 0; a < (1 << ADDRW); a++)
      mem[a] = {$urandom, $urandom, $urandom, $urandom};
    mem[0] = 128'hDEAD;
    model_reset();
    do_reset(2);

    // Issue only, addresses 5,6,7 back to back
    step(1, 6'd5, 2'b00, '0); check("s1_ready0", issue_ready, 1);
    step(1, 6'd6, 2'b00, '0); check("s1_data5", issue_rsp_data, mem[5]);
    step(1, 6'd7, 2'b00, '0); check("s1_data6", issue_rsp_data, mem[6]);
    step(0, 6'd0, 2'b00, '0); check("s1_data7", issue_rsp_data, mem[7]);

    // Issue always valid, aux0 starves for four cycles then is forced
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      step(1, 6'd9, 2'b01, {6'd3, 6'd12});
      check("s2_issue_ready", issue_ready, (c < 4) ? 1 : 0);
      check("s2_aux_ready", aux_ready, (c == 4) ? 2'b01 : 2'b00);
    end
`ifdef GPR_ARB_PERF_EN
    @(posedge clk); #1;
    check("s2_perf_stalls", perf_issue_stalls, 1);
    check("s2_perf_aux", perf_aux_grants, 1);
    check("s2_perf_forced", perf_forced_grants, 1);
`endif
    step(1, 6'd9, 2'b01, {6'd3, 6'd12});
    check("s2_aux_rsp_valid", aux_rsp_valid, 1);
    check("s2_aux_rsp_idx", aux_rsp_idx, 0);
    check("s2_issue_back", issue_ready, 1);
    step(0, 6'd0, 2'b00, '0);

    // Two aux requesters, no issue: strict alternation
    do_reset(1);
    for (int c = 0; c < 5; c++) begin
      step(0, 6'd0, 2'b11, {6'd20, 6'd21});
      check("s3_aux_ready", aux_ready, (c % 2) ? 2'b10 : 2'b01);
      if (c > 0) check("s3_rsp_idx", aux_rsp_idx, (c - 1) % 2);
    end
    step(0, 6'd0, 2'b00, '0);

    // Address 0: zero for issue, raw for aux
    step(1, 6'd0, 2'b00, '0);
    step(0, 6'd0, 2'b01, {6'd0, 6'd0}); check("s4_issue_zero", issue_rsp_data, 0);
    step(0, 6'd0, 2'b00, '0);           check("s4_aux_raw", aux_rsp_data, 128'hDEAD);

    // Reset right after an aux grant
    do_reset(1);
    step(0, 6'd0, 2'b01, {6'd4, 6'd8});
    step(0, 6'd0, 2'b01, {6'd4, 6'd8});  // rr now favours requester 1
    do_reset(1);
    step(0, 6'd0, 2'b11, {6'd4, 6'd8});
    check("s5_first_grant", aux_ready, 2'b01);
    check("s5_no_rsp", aux_rsp_valid, 0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 79) == 0) do_reset(1);
      step(($urandom_range(0, 3) != 0), ADDRW'($urandom), N'($urandom), (N*ADDRW)'($urandom));
    end
    step(0, 6'd0, 2'b00, '0);

`ifdef GPR_ARB_PERF_EN
    @(posedge clk); #1;
    check("perf_stalls", perf_issue_stalls, m_stalls);
    check("perf_aux", perf_aux_grants, m_aux_grants);
    check("perf_forced", perf_forced_grants, m_forced);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
